spi_cmd_seq: RTL
================

// Module: spi_cmd_seq
// PURPOSE
//  Command sequencer upstream of the SPI byte engine. Takes one command (opcode, optional address, N data bytes)
//  and turns it into a series of single-byte engine requests. Write bytes come from a valid/ready stream; read bytes
//  go out on a valid/ready stream. Flash and peripheral control logic talk to this block, never to the byte engine.
// PARAMETERS
//  ADDR_BYTES   3    address bytes sent MSB first when cmd_has_addr=1 (1..4)
//  LEN_W        8    width of cmd_len; max data bytes per command = 2^LEN_W-1
//  DUMMY_BYTES  1    dummy 0x00 bytes after address (only with SPI_CMD_DUMMY_EN)
//  TIMEOUT      64   clk_in cycles allowed for spi_busy to rise after a request
// PORTS
//  clk_in        in   1              system clock
//  reset         in   1              asynchronous, active-high reset
//  cmd_valid     in   1              command present
//  cmd_ready     out  1              high in IDLE only; command accepted when cmd_valid&cmd_ready
//  cmd_opcode    in   8              first byte sent
//  cmd_addr      in   ADDR_BYTES*8   address, sent MSB byte first
//  cmd_has_addr  in   1              1: send address phase
//  cmd_rnw       in   1              1: data phase reads; 0: data phase writes
//  cmd_len       in   LEN_W          data-phase byte count; 0 = no data phase
//  wr_data       in   8              write byte
//  wr_valid      in   1              write byte present
//  wr_ready      out  1              1-cycle pulse: wr_data consumed this cycle
//  rd_data       out  8              read byte, held while rd_valid
//  rd_valid      out  1              read byte present, held until rd_ready
//  rd_ready      in   1              consumer accepts rd_data
//  done          out  1              1-cycle pulse when the command completes
//  err           out  1              1-cycle pulse with done if a timeout aborted the command
//  busy          out  1              high from command accept to done
//  spi_read      out  1              byte-engine read request, 1-cycle pulse
//  spi_write     out  1              byte-engine write request, 1-cycle pulse
//  spi_din       out  8              byte to the engine, valid with spi_write
//  spi_dout      in   8              byte from the engine, valid when spi_busy falls after a read
//  spi_busy      in   1              engine busy
// BEHAVIOUR
//  Reset values
//  - All outputs 0 except cmd_ready=1.
//  - State IDLE; counters 0.
//  - Reset mid-command abandons it with no done pulse.
//  Phase FSM: IDLE -> OPC -> ADDR (if cmd_has_addr) -> DUMMY (if enabled and has_addr) -> DATA (if cmd_len!=0) -> FIN -> IDLE.
//  - On accept: latch opcode, addr, rnw and len.
//  - busy=1 and cmd_ready=0 on the next cycle.
//  Byte sub-FSM, per byte: REQ -> WAIT_HI -> WAIT_LO.
//  - REQ: wait for spi_busy=0, then pulse spi_write or spi_read for exactly one cycle.
//  - spi_din is driven in that same cycle.
//  - WAIT_HI: wait for spi_busy=1. More than TIMEOUT cycles: abort to FIN with err=1.
//  - WAIT_LO: wait for spi_busy=0, then advance to the next byte or phase.
//  Write data
//  - In REQ with rnw=0: the request is issued only when wr_valid=1.
//  - wr_ready pulses in the same cycle as spi_write.
//  - Starvation stalls in REQ with no timeout. The engine may raise CS between stalled bytes.
//  Read data
//  - Each read byte: spi_read pulse, then capture spi_dout in the cycle spi_busy is seen falling.
//  - Set rd_valid, hold rd_data.
//  - The next spi_read is not issued while rd_valid=1 and rd_ready=0 (backpressure stalls the bus).
//  - rd_valid clears on rd_valid&rd_ready. A same-cycle new capture wins: rd_valid stays 1 with the new data.
//  Ordering and counts
//  - Address bytes: cmd_addr[ADDR_BYTES*8-1 -: 8] first.
//  - Dummy bytes are written as 0x00.
//  - Data counter counts down from cmd_len to 0; decrements at the end of WAIT_LO.
//  - cmd_len = all ones is legal.
//  Completion
//  - FIN waits for spi_busy=0 and rd_valid=0, then pulses done.
//  - IDLE, cmd_ready=1 on the following cycle.
//  Misc
//  - spi_read and spi_write are never both 1.
//  - No request while spi_busy=1.
// CONFIGURATION
//  SPI_CMD_DUMMY_EN
//  - Defined: DUMMY phase of DUMMY_BYTES 0x00 writes follows the address phase when cmd_has_addr=1.
//  - Not defined: DUMMY phase and DUMMY_BYTES logic absent. Address goes straight to DATA; DUMMY_BYTES ignored.
// TESTING
//  Use a behavioural byte-engine model: busy rises 1 cycle after a request and stays high 17 cycles; reads return
//  a scripted sequence.
//  1. opcode 0x06, has_addr=0, len=0
//     -> one spi_write with spi_din=0x06, one done, err=0, no wr_ready/rd_valid.
//  2. opcode 0x03, addr 0x123456, rnw=1, len=4, model returns A1 B2 C3 D4
//     -> writes 03 12 34 56; four reads; rd_data A1,B2,C3,D4 in order; done after the last rd accept.
//  3. opcode 0x02, addr 0x000100, rnw=0, len=3, wr_valid withheld 40 cycles before byte 2
//     -> writes 02 00 01 00 11 22 33; stall in REQ with no err; wr_ready exactly 3 pulses.
//  4. Read len=2 with rd_ready=0 for 100 cycles after byte 1
//     -> no second spi_read until rd_ready; rd_data stable; both bytes delivered.
//  5. Model never raises busy
//     -> err and done pulse together TIMEOUT+1 cycles after the request; cmd_ready returns.
//  6. reset pulsed during the ADDR phase; with SPI_CMD_DUMMY_EN, opcode 0x0B, addr 0, len=1
//     -> after reset all outputs at reset values with no done; the 0x0B command writes 0B 00 00 00 00 then reads 1 byte.

Source files
------------

// File: rtl/spi_cmd_seq.sv
// spi_cmd_seq: sequences one opcode/address/data command into single-byte SPI engine requests
// Ports: clk_in, reset (async, active-high); cmd_* command handshake (cmd_ready high only in IDLE);
//   wr_data/wr_valid/wr_ready write-byte stream in; rd_data/rd_valid/rd_ready read-byte stream out;
//   done/err 1-cycle completion pulses, busy from accept to done;
//   spi_read/spi_write/spi_din requests to the byte engine, spi_dout/spi_busy back from it.
// Optional: define SPI_CMD_DUMMY_EN to send DUMMY_BYTES 0x00 writes after the address phase.
module spi_cmd_seq #(
  parameter int ADDR_BYTES  = 3,
  parameter int LEN_W       = 8,
  parameter int DUMMY_BYTES = 1,
  parameter int TIMEOUT     = 64
) (
  input  logic                    clk_in,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [7:0]              cmd_opcode,
  input  logic [ADDR_BYTES*8-1:0] cmd_addr,
  input  logic                    cmd_has_addr,
  input  logic                    cmd_rnw,
  input  logic [LEN_W-1:0]        cmd_len,
  input  logic [7:0]              wr_data,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  output logic [7:0]              rd_data,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic                    done,
  output logic                    err,
  output logic                    busy,
  output logic                    spi_read,
  output logic                    spi_write,
  output logic [7:0]              spi_din,
  input  logic [7:0]              spi_dout,
  input  logic                    spi_busy
);
  localparam int AW    = ADDR_BYTES * 8;
  localparam int IDX_W = $clog2((ADDR_BYTES > DUMMY_BYTES ? ADDR_BYTES : DUMMY_BYTES) + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {
    IDLE, OPC, ADDR,
`ifdef SPI_CMD_DUMMY_EN
    DUMMY,
`endif
    DATA, FIN
  } phase_t;
  typedef enum logic [1:0] {REQ, WAIT_HI, WAIT_LO} sub_t;
  phase_t            phase_q, phase_d, after_hdr;
  sub_t              sub_q, sub_d;
  logic [7:0]        opc_q, opc_d, rd_data_q, rd_data_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic              has_addr_q, has_addr_d, rnw_q, rnw_d, err_q, err_d, rd_valid_q, rd_valid_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              byte_ph, data_ph, can_req, byte_end, capture;
  always_ff @(posedge clk_in or posedge reset)
    if (reset) begin
      phase_q    <= IDLE;
      sub_q      <= REQ;
      opc_q      <= '0;
      addr_q     <= '0;
      has_addr_q <= 1'b0;
      rnw_q      <= 1'b0;
      len_q      <= '0;
      idx_q      <= '0;
      tmo_q      <= '0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      phase_q    <= phase_d;
      sub_q      <= sub_d;
      opc_q      <= opc_d;
      addr_q     <= addr_d;
      has_addr_q <= has_addr_d;
      rnw_q      <= rnw_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      tmo_q      <= tmo_d;
      err_q      <= err_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  always_comb begin
    phase_d    = phase_q;
    sub_d      = sub_q;
    opc_d      = opc_q;
    addr_d     = addr_q;
    has_addr_d = has_addr_q;
    rnw_d      = rnw_q;
    len_d      = len_q;
    idx_d      = idx_q;
    tmo_d      = tmo_q;
    err_d      = err_q;
    byte_end   = byte_ph && sub_q == WAIT_LO && !spi_busy;
    capture    = byte_end && data_ph && rnw_q;
    after_hdr  = len_q != '0 ? DATA : FIN;
    // a fresh capture overrides a same-cycle consumer accept
    rd_valid_d = capture ? 1'b1 : rd_ready ? 1'b0 : rd_valid_q;
    rd_data_d  = capture ? spi_dout : rd_data_q;
    if (phase_q == IDLE && cmd_valid) begin
      phase_d    = OPC;
      sub_d      = REQ;
      opc_d      = cmd_opcode;
      addr_d     = cmd_addr;
      has_addr_d = cmd_has_addr;
      rnw_d      = cmd_rnw;
      len_d      = cmd_len;
      idx_d      = '0;
      err_d      = 1'b0;
    end
    if (phase_q == FIN && done)
      phase_d = IDLE;
    if (byte_ph && sub_q == REQ && (spi_read || spi_write)) begin
      sub_d = WAIT_HI;
      tmo_d = '0;
    end
    if (byte_ph && sub_q == WAIT_HI) begin
      if (spi_busy)
        sub_d = WAIT_LO;
      else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
        phase_d = FIN;
        sub_d   = REQ;
        err_d   = 1'b1;
      end else
        tmo_d = tmo_q + TMO_W'(1);
    end
    if (byte_end) begin
      sub_d = REQ;
      if (phase_q == OPC) begin
        phase_d = has_addr_q ? ADDR : after_hdr;
        idx_d   = '0;
      end
      if (phase_q == ADDR) begin
        addr_d = addr_q << 8;
        idx_d  = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(ADDR_BYTES - 1)) begin
          idx_d = '0;
`ifdef SPI_CMD_DUMMY_EN
          phase_d = DUMMY;
`else
          phase_d = after_hdr;
`endif
        end
      end
`ifdef SPI_CMD_DUMMY_EN
      if (phase_q == DUMMY) begin
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(DUMMY_BYTES - 1)) begin
          idx_d   = '0;
          phase_d = after_hdr;
        end
      end
`endif
      if (data_ph) begin
        len_d = len_q - LEN_W'(1);
        if (len_q == LEN_W'(1))
          phase_d = FIN;
      end
    end
  end
  always_comb begin
    byte_ph   = phase_q != IDLE && phase_q != FIN;
    data_ph   = phase_q == DATA;
    can_req   = byte_ph && sub_q == REQ && !spi_busy;
    // a held, unaccepted read byte blocks the next read request
    spi_read  = can_req && data_ph && rnw_q && (!rd_valid_q || rd_ready);
    spi_write = can_req && !(data_ph && (rnw_q || !wr_valid));
    wr_ready  = spi_write && data_ph;
    spi_din   = !spi_write ? 8'h00 : phase_q == OPC ? opc_q : phase_q == ADDR ? addr_q[AW-1 -: 8] : data_ph ? wr_data : 8'h00;
    done      = phase_q == FIN && !spi_busy && !rd_valid_q;
    err       = done && err_q;
    busy      = phase_q != IDLE;
    cmd_ready = phase_q == IDLE;
    rd_valid  = rd_valid_q;
    rd_data   = rd_data_q;
  end
endmodule
